// File: rtl/sr_mdu_if.sv
// Request/result bundle between the execute stage and the iterative multiply/divide unit.
interface sr_mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       oper;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, oper, srcA, srcB, flush, input busy, done, result);
  modport slave  (input start, oper, srcA, srcB, flush, output busy, done, result);
endinterface

// File: rtl/sr_mdu.sv
// Radix-2 iterative RV32M-style multiply/divide unit: shift-add multiply, restoring divide,
// sign handled by magnitude capture on accept and correction in the final cycle.
module sr_mdu #(
  parameter int unsigned WIDTH        = 32,
  parameter bit          FAST_SPECIAL = 1'b1
) (
  input  logic    clk,
  input  logic    rst,
  sr_mdu_if.slave mdu
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SIGN_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} stateT;

  stateT              mdState;
  logic [2:0]         opReg;
  logic               signA;
  logic               signB;
  logic               dzFlag;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   operand;   // multiplicand for multiply, divisor for divide
  logic [2*WIDTH-1:0] acc;       // product; low half is dividend/quotient for divide
  logic [WIDTH-1:0]   rem;

  logic               inSignA;
  logic               inSignB;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic               divZero;
  logic               divOvf;
  logic [WIDTH:0]     mulAdd;
  logic [WIDTH:0]     divShift;
  logic [WIDTH-1:0]   divDiff;
  logic               divFits;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;
  logic [WIDTH-1:0]   resSel;

  // Operand decode, one iteration step and final sign correction.
  always_comb begin
    inSignA  = 1'b0;
    inSignB  = 1'b0;
    case (mdu.oper)
      3'b001, 3'b100, 3'b110: begin
        inSignA = mdu.srcA[WIDTH-1];
        inSignB = mdu.srcB[WIDTH-1];
      end
      3'b010:  inSignA = mdu.srcA[WIDTH-1];
      default: ;
    endcase
    magA     = inSignA ? -mdu.srcA : mdu.srcA;
    magB     = inSignB ? -mdu.srcB : mdu.srcB;
    divZero  = mdu.oper[2] && (mdu.srcB == '0);
    divOvf   = mdu.oper[2] && !mdu.oper[0] && (mdu.srcA == SIGN_MIN) && (mdu.srcB == '1);

    mulAdd   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    divShift = {rem, acc[WIDTH-1]};
    divFits  = divShift >= {1'b0, operand};
    divDiff  = divShift[WIDTH-1:0] - operand;

    prodFix  = (signA ^ signB) ? -acc : acc;
    quoFix   = ((signA ^ signB) && !dzFlag) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    remFix   = signA ? -rem : rem;
    case (opReg)
      3'b000:                 resSel = prodFix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: resSel = prodFix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         resSel = quoFix;
      default:                resSel = remFix;
    endcase
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdState    <= IDLE;
      mdu.busy   <= 1'b0;
      mdu.done   <= 1'b0;
      mdu.result <= '0;
      opReg      <= '0;
      signA      <= 1'b0;
      signB      <= 1'b0;
      dzFlag     <= 1'b0;
      cnt        <= '0;
      operand    <= '0;
      acc        <= '0;
      rem        <= '0;
    end else begin
      mdu.done <= 1'b0;
      if (mdu.flush) begin
        mdState  <= IDLE;
        mdu.busy <= 1'b0;
      end else begin
        case (mdState)
          IDLE: begin
            if (mdu.start) begin
              opReg    <= mdu.oper;
              signA    <= inSignA;
              signB    <= inSignB;
              dzFlag   <= divZero;
              cnt      <= CW'(WIDTH - 1);
              mdu.busy <= 1'b1;
              operand  <= mdu.oper[2] ? magB : magA;
              acc      <= {{WIDTH{1'b0}}, (mdu.oper[2] ? magA : magB)};
              rem      <= '0;
              mdState  <= CALC;
              // Special divides preload the final quotient/remainder magnitudes.
              if (FAST_SPECIAL && (divZero || divOvf)) begin
                acc     <= {{WIDTH{1'b0}}, (divZero ? {WIDTH{1'b1}} : magA)};
                rem     <= divZero ? magA : '0;
                mdState <= FIN;
              end
            end
          end
          CALC: begin
            if (opReg[2]) begin
              rem            <= divFits ? divDiff : divShift[WIDTH-1:0];
              acc[WIDTH-1:0] <= {acc[WIDTH-2:0], divFits};
            end else begin
              acc <= {mulAdd, acc[WIDTH-1:1]};
            end
            if (cnt == '0) mdState <= FIN;
            else           cnt     <= cnt - 1'b1;
          end
          FIN: begin
            mdu.result <= resSel;
            mdu.done   <= 1'b1;
            mdu.busy   <= 1'b0;
            mdState    <= IDLE;
          end
          default: mdState <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sr_mdu.sv
// Bench for sr_mdu: drives one fast-special and one full-iteration instance with identical stimulus.
module tb_sr_mdu;
  localparam int unsigned W = 32;

  logic          clk;
  logic          rst;
  logic          start;
  logic          flush;
  logic [2:0]    oper;
  logic [W-1:0]  srcA;
  logic [W-1:0]  srcB;
  logic [W-1:0]  lastExp;
  int            checks;
  int            failures;
  int            doneSeen;

  sr_mdu_if #(.WIDTH(W)) ifF ();
  sr_mdu_if #(.WIDTH(W)) ifS ();

  assign ifF.start = start;
  assign ifF.flush = flush;
  assign ifF.oper  = oper;
  assign ifF.srcA  = srcA;
  assign ifF.srcB  = srcB;
  assign ifS.start = start;
  assign ifS.flush = flush;
  assign ifS.oper  = oper;
  assign ifS.srcA  = srcA;
  assign ifS.srcB  = srcB;

  sr_mdu #(.WIDTH(W), .FAST_SPECIAL(1'b1)) dutF (.clk(clk), .rst(rst), .mdu(ifF));
  sr_mdu #(.WIDTH(W), .FAST_SPECIAL(1'b0)) dutS (.clk(clk), .rst(rst), .mdu(ifS));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural RV32M result computed with 64-bit integer arithmetic.
  function automatic logic [31:0] refMdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    longint p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p  = 0;
    case (op)
      3'd0: p = ua * ub;
      3'd1: p = (sa * sb) >>> 32;
      3'd2: p = (sa * ub) >>> 32;
      3'd3: p = (ua * ub) >> 32;
      3'd4: p = (b == 0) ? -1 : sa / sb;
      3'd5: p = (b == 0) ? -1 : ua / ub;
      3'd6: p = (b == 0) ? sa : sa % sb;
      default: p = (b == 0) ? ua : ua % ub;
    endcase
    return p[31:0];
  endfunction

  function automatic bit isSpecial(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One operation on both instances; optional start pulse with junk operands while busy.
  task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int glitchAt);
    logic [31:0] resF;
    logic [31:0] resS;
    int latF;
    int latS;
    int expLatF;
    resF = '0; resS = '0; latF = -1; latS = -1;
    oper = op; srcA = a; srcB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "/busy"}, 32'(ifS.busy), 32'd1);
    for (int i = 1; i <= 60 && (latF < 0 || latS < 0); i++) begin
      if (i == glitchAt) begin
        start = 1'b1; oper = 3'($urandom_range(0, 7)); srcA = $urandom; srcB = $urandom;
      end else if (i == glitchAt + 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (latF < 0 && ifF.done) begin latF = i; resF = ifF.result; end
      if (latS < 0 && ifS.done) begin latS = i; resS = ifS.result; end
    end
    start   = 1'b0;
    expLatF = isSpecial(op, a, b) ? 1 : W + 1;
    check({tag, "/fast"},    resF, exp);
    check({tag, "/slow"},    resS, exp);
    check({tag, "/latFast"}, 32'(latF), 32'(expLatF));
    check({tag, "/latSlow"}, 32'(latS), 32'(W + 1));
    lastExp = exp;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    checks = 0; failures = 0; lastExp = '0;
    rst = 1'b1; start = 1'b0; flush = 1'b0; oper = '0; srcA = '0; srcB = '0;
    #12;
    check("rstBusyF", 32'(ifF.busy), 32'd0);
    check("rstDoneF", 32'(ifF.done), 32'd0);
    check("rstResF",  ifF.result,    32'd0);
    check("rstBusyS", 32'(ifS.busy), 32'd0);
    check("rstDoneS", 32'(ifS.done), 32'd0);
    check("rstResS",  ifS.result,    32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    runOp("mulhu",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, -1);
    runOp("mul",       3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, -1);
    runOp("mulh",      3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, -1);
    runOp("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    runOp("div",       3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, -1);
    runOp("rem",       3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, -1);
    runOp("divu",      3'd5, 32'd100,       32'd7,         32'd14,        -1);
    runOp("remu",      3'd7, 32'd100,       32'd7,         32'd2,         -1);
    runOp("divuZero",  3'd5, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, -1);
    runOp("remOvf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         -1);
    runOp("divOvf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, -1);
    runOp("divZeroN",  3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, -1);
    runOp("remZeroN",  3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, -1);
    runOp("remuZero",  3'd7, 32'h0000_1234, 32'd0,         32'h0000_1234, -1);
    runOp("startBusy", 3'd5, 32'd100,       32'd7,         32'd14,         5);

    for (int n = 0; n < 60; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      runOp("rand", rop, ra, rb, refMdu(rop, ra, rb), -1);
    end

    // Flush sampled at the tenth edge after accept.
    oper = 3'd3; srcA = $urandom; srcB = $urandom; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flushBusyF", 32'(ifF.busy), 32'd0);
    check("flushBusyS", 32'(ifS.busy), 32'd0);
    doneSeen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ifF.done || ifS.done) doneSeen++;
    end
    check("flushNoDone", 32'(doneSeen), 32'd0);
    check("flushResF",   ifF.result, lastExp);
    check("flushResS",   ifS.result, lastExp);

    // Flush beats start in IDLE.
    flush = 1'b1; start = 1'b1; oper = 3'd0; srcA = 32'd3; srcB = 32'd5;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flushStartF", 32'(ifF.busy), 32'd0);
    check("flushStartS", 32'(ifS.busy), 32'd0);

    // Asynchronous reset between edges while iterating.
    runOp("preRst", 3'd0, 32'd1234, 32'd5678, 32'd7006652, -1);
    oper = 3'd3; srcA = $urandom; srcB = $urandom; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arstBusyF", 32'(ifF.busy), 32'd0);
    check("arstDoneF", 32'(ifF.done), 32'd0);
    check("arstResF",  ifF.result,    32'd0);
    check("arstBusyS", 32'(ifS.busy), 32'd0);
    check("arstDoneS", 32'(ifS.done), 32'd0);
    check("arstResS",  ifS.result,    32'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    runOp("mul6x7", 3'd0, 32'd6, 32'd7, 32'd42, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
